// File: rtl/tl_pkg.sv
// Shared transaction-layer definitions: link state encoding, arbitration
// mode constants and an index-width helper.
package tl_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } tl_state_e;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  // Index width for n items, never below one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Single-grant arbiter: fixed priority from index 0, or round-robin starting
// at the supplied pointer and wrapping modulo NUM_CH.
module rr_arbiter
  import tl_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              mode,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_valid
);

  int start;
  int idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    start     = (mode == ARB_RR) ? (int'(ptr) % NUM_CH) : 0;
    idx       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (start + k) % NUM_CH;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_rr_router.sv
// NUM_CH x NUM_CH router: one FIFO head per cycle into a registered slot per
// destination, with per-output backpressure and out-of-range drop counting.
//   state     | meaning
//   ST_INIT   | link in INIT: no pops, slots/counters/pointer held at zero
//   ST_IDLE   | ready, nothing forwarded recently
//   ST_ACTIVE | forwarding; returns to IDLE after an empty, grantless cycle
module mux_rr_router
  import tl_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 10,
  parameter int DEST_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     init,
  input  logic                     arb_mode,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_pop,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*CNT_W-1:0]  fwd_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     active
);

  localparam int IDX_W = clog2(NUM_CH);

  tl_state_e                     state_q, state_d;
  logic [IDX_W-1:0]              ptr_q, ptr_d;
  logic [NUM_CH-1:0]             valid_q, valid_d;
  logic [NUM_CH-1:0][DATA_W-1:0] data_q, data_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  fwd_q, fwd_d;
  logic [CNT_W-1:0]              drop_q, drop_d;

  logic [NUM_CH-1:0][DEST_W-1:0] dest;
  logic [NUM_CH-1:0]             in_range, slot_free, req, gnt;
  logic [IDX_W-1:0]              gnt_idx;
  logic                          gnt_valid, grant_en, gnt_in_range;
  logic [DATA_W-1:0]             gnt_word;
  logic [DEST_W-1:0]             gnt_dest;

  assign grant_en = (state_q != ST_INIT) && !init;

  // A blocked destination only masks its own requester, never the others.
  always_comb begin
    dest      = '0;
    in_range  = '0;
    slot_free = '0;
    req       = '0;
    for (int d = 0; d < NUM_CH; d++) slot_free[d] = !valid_q[d] || out_ready[d];
    for (int i = 0; i < NUM_CH; i++) begin
      dest[i]     = in_data[i*DATA_W + DATA_W - 1 -: DEST_W];
      in_range[i] = 32'(dest[i]) < NUM_CH;
      if (in_valid[i] && grant_en) begin
        if (!in_range[i]) req[i] = 1'b1;
        for (int d = 0; d < NUM_CH; d++)
          if (in_range[i] && 32'(dest[i]) == d && slot_free[d]) req[i] = 1'b1;
      end
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .mode      (arb_mode),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign in_pop = gnt;

  always_comb begin
    gnt_word = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (gnt[i]) gnt_word = in_data[i*DATA_W +: DATA_W];
    gnt_dest     = gnt_word[DATA_W-1 -: DEST_W];
    gnt_in_range = 32'(gnt_dest) < NUM_CH;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    fwd_d   = fwd_q;
    drop_d  = drop_q;
    if (init || state_q == ST_INIT) begin
      state_d = init ? ST_INIT : ST_IDLE;
      ptr_d   = '0;
      valid_d = '0;
      data_d  = '0;
      fwd_d   = '0;
      drop_d  = '0;
    end else begin
      for (int d = 0; d < NUM_CH; d++) begin
        if (valid_q[d] && out_ready[d]) begin
          valid_d[d] = 1'b0;
          data_d[d]  = '0;
          fwd_d[d]   = fwd_q[d] + CNT_W'(1);
        end
      end
      // Loading after the drain lets a slot empty and refill on one edge.
      if (gnt_valid) begin
        if (gnt_in_range) begin
          for (int d = 0; d < NUM_CH; d++) begin
            if (32'(gnt_dest) == d) begin
              valid_d[d] = 1'b1;
              data_d[d]  = gnt_word;
            end
          end
        end else begin
          drop_d = drop_q + CNT_W'(1);
        end
        if (arb_mode == ARB_RR)
          ptr_d = (32'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + IDX_W'(1);
      end
      case (state_q)
        ST_IDLE:   if (gnt_valid) state_d = ST_ACTIVE;
        ST_ACTIVE: if (!gnt_valid && valid_q == '0) state_d = ST_IDLE;
        default:   state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      valid_q <= '0;
      data_q  <= '0;
      fwd_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      fwd_q   <= fwd_d;
      drop_q  <= drop_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign fwd_cnt   = fwd_q;
  assign drop_cnt  = drop_q;
  assign active    = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_mux_rr_router.sv
// Bench for mux_rr_router: 4-channel instance checked every cycle against a
// behavioural model, plus a 3-channel instance for out-of-range drops.
module tb_mux_rr_router;

  localparam int N  = 4;
  localparam int DW = 10;
  localparam int CW = 8;

  logic            clk, reset_L, init, arb_mode;
  logic [N*DW-1:0] in_data, out_data;
  logic [N-1:0]    in_valid, in_pop, out_valid, out_ready;
  logic [N*CW-1:0] fwd_cnt;
  logic [CW-1:0]   drop_cnt;
  logic            active;

  logic [3*DW-1:0] in_data3, out_data3;
  logic [2:0]      in_valid3, in_pop3, out_valid3, out_ready3;
  logic [3*CW-1:0] fwd_cnt3;
  logic [CW-1:0]   drop_cnt3;
  logic            active3, arb_mode3;

  int tests, fails;

  mux_rr_router #(.NUM_CH(N), .DATA_W(DW), .DEST_W(2), .CNT_W(CW)) u_dut (
    .clk(clk), .reset_L(reset_L), .init(init), .arb_mode(arb_mode),
    .in_data(in_data), .in_valid(in_valid), .in_pop(in_pop),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt), .active(active)
  );

  mux_rr_router #(.NUM_CH(3), .DATA_W(DW), .DEST_W(2), .CNT_W(CW)) u_dut3 (
    .clk(clk), .reset_L(reset_L), .init(init), .arb_mode(arb_mode3),
    .in_data(in_data3), .in_valid(in_valid3), .in_pop(in_pop3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .fwd_cnt(fwd_cnt3), .drop_cnt(drop_cnt3), .active(active3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, run not finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: slots, counters, pointer and link state as plain data.
  logic          m_valid [N];
  logic [DW-1:0] m_data  [N];
  logic [CW-1:0] m_fwd   [N];
  logic [CW-1:0] m_drop;
  int            m_ptr;
  int            m_state;  // 0 init, 1 idle, 2 active

  task automatic m_clear();
    for (int d = 0; d < N; d++) begin
      m_valid[d] = 1'b0;
      m_data[d]  = '0;
      m_fwd[d]   = '0;
    end
    m_drop = '0;
    m_ptr  = 0;
  endtask

  function automatic int dest_of(input int i);
    logic [DW-1:0] w;
    w = in_data[i*DW +: DW];
    return int'(w[DW-1 -: 2]);
  endfunction

  function automatic int m_pick();
    int start;
    if (!reset_L || init || m_state == 0) return -1;
    start = arb_mode ? m_ptr : 0;
    for (int k = 0; k < N; k++) begin
      int c, d;
      c = (start + k) % N;
      d = dest_of(c);
      if (in_valid[c] && (d >= N || !m_valid[d] || out_ready[d])) return c;
    end
    return -1;
  endfunction

  task automatic m_step();
    int g, d;
    bit any;
    g = m_pick();
    if (!reset_L) begin
      m_clear(); m_state = 0;
    end else if (init || m_state == 0) begin
      m_clear(); m_state = init ? 0 : 1;
    end else begin
      any = 1'b0;
      for (int s = 0; s < N; s++) any |= m_valid[s];
      for (int s = 0; s < N; s++)
        if (m_valid[s] && out_ready[s]) begin
          m_valid[s] = 1'b0;
          m_fwd[s]   = m_fwd[s] + 8'd1;
        end
      if (g >= 0) begin
        d = dest_of(g);
        if (d < N) begin
          m_valid[d] = 1'b1;
          m_data[d]  = in_data[g*DW +: DW];
        end else m_drop = m_drop + 8'd1;
        if (arb_mode) m_ptr = (g + 1) % N;
      end
      if (m_state == 1 && g >= 0) m_state = 2;
      else if (m_state == 2 && g < 0 && !any) m_state = 1;
    end
  endtask

  // Per-cycle comparison on the falling edge, model advance on the rising edge.
  initial begin
    logic [N-1:0] ev;
    int g;
    m_clear();
    m_state = 0;
    forever begin
      @(negedge clk);
      if (!reset_L) begin m_clear(); m_state = 0; end
      g = m_pick();
      check("model in_pop", in_pop, (g < 0) ? 0 : (1 << g));
      for (int d = 0; d < N; d++) begin
        ev[d] = m_valid[d];
        check("model out_data", out_data[d*DW +: DW], m_valid[d] ? m_data[d] : '0);
        check("model fwd_cnt", fwd_cnt[d*CW +: CW], m_fwd[d]);
      end
      check("model out_valid", out_valid, ev);
      check("model drop_cnt", drop_cnt, m_drop);
      check("model active", active, m_state == 2);
      @(posedge clk);
      m_step();
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] w);
    in_data[i*DW +: DW] = w;
  endtask

  initial begin
    logic [N-1:0] seq_f [3];
    logic [N-1:0] seq_rr [5];
    logic [N-1:0] seq_t5 [3];
    logic [CW-1:0] f0;
    tests = 0; fails = 0;
    seq_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    seq_f  = '{4'b0001, 4'b0001, 4'b0001};
    seq_t5 = '{4'b0010, 4'b0100, 4'b0001};
    reset_L = 1'b1; init = 1'b1; arb_mode = 1'b0; arb_mode3 = 1'b0;
    in_valid = '0; in_data = '0; out_ready = '1;
    in_valid3 = '0; in_data3 = '0; out_ready3 = '1;
    #2 reset_L = 1'b0;
    cyc(2);
    in_valid = 4'b1111;
    #1;
    check("reset in_pop", in_pop, 4'b0000);
    check("reset out_valid", out_valid, 4'b0000);
    check("reset fwd_cnt", fwd_cnt, 0);
    check("reset drop_cnt", drop_cnt, 0);
    check("reset active", active, 0);
    in_valid = '0;
    reset_L = 1'b1;
    cyc();
    init = 1'b0;
    cyc();

    // Basic forwarding
    set_word(0, 10'h2A5); in_valid = 4'b0001;
    #1 check("t1 in_pop", in_pop, 4'b0001);
    cyc();
    in_valid = '0;
    #1;
    check("t1 out_valid", out_valid, 4'b0100);
    check("t1 out_data2", out_data[2*DW +: DW], 10'h2A5);
    check("t1 active", active, 1);
    cyc();
    #1;
    check("t1 fwd_cnt2", fwd_cnt[2*CW +: CW], 1);
    check("t1 out_valid drained", out_valid, 4'b0000);

    // Arbitration modes
    set_word(0, 10'h010); set_word(1, 10'h111); set_word(2, 10'h212); set_word(3, 10'h313);
    in_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin #1 check("t2 fixed in_pop", in_pop, seq_f[k]); cyc(); end
    arb_mode = 1'b1;
    for (int k = 0; k < 5; k++) begin #1 check("t2 rr in_pop", in_pop, seq_rr[k]); cyc(); end
    in_valid = '0; arb_mode = 1'b0;
    cyc(2);

    // Backpressure bypass
    out_ready = 4'b1101;
    set_word(0, 10'h155); in_valid = 4'b0001;
    #1 check("t3 load in_pop", in_pop, 4'b0001);
    cyc();
    set_word(0, 10'h1AA); set_word(2, 10'h3C3); in_valid = 4'b0101;
    #1;
    check("t3 bypass in_pop", in_pop, 4'b0100);
    check("t3 slot1 held", out_data[1*DW +: DW], 10'h155);
    cyc();
    in_valid = 4'b0001;
    #1;
    check("t3 blocked in_pop", in_pop, 4'b0000);
    check("t3 out_valid", out_valid, 4'b1010);
    check("t3 out_data3", out_data[3*DW +: DW], 10'h3C3);
    check("t3 slot1 unchanged", out_data[1*DW +: DW], 10'h155);
    out_ready = '1;
    #1 check("t3 unblocked in_pop", in_pop, 4'b0001);
    cyc();
    #1 check("t3 slot1 refilled", out_data[1*DW +: DW], 10'h1AA);
    in_valid = '0;
    cyc();

    // Drain and refill in one edge
    out_ready = '0; set_word(0, 10'h011); in_valid = 4'b0001;
    #1 check("t4 load in_pop", in_pop, 4'b0001);
    cyc();
    set_word(0, 10'h022); out_ready = 4'b0001; f0 = m_fwd[0];
    #1 check("t4 refill in_pop", in_pop, 4'b0001);
    cyc();
    #1;
    check("t4 out_valid0", out_valid[0], 1);
    check("t4 out_data0", out_data[0 +: DW], 10'h022);
    check("t4 fwd_cnt0", fwd_cnt[0 +: CW], f0 + 8'd1);
    in_valid = '0; out_ready = '1;
    cyc();

    // Init mid-stream with three slots held
    arb_mode = 1'b1; out_ready = '0;
    set_word(0, 10'h0A0); set_word(1, 10'h1B1); set_word(2, 10'h2C2);
    in_valid = 4'b0111;
    for (int k = 0; k < 3; k++) begin #1 check("t5 rr fill in_pop", in_pop, seq_t5[k]); cyc(); end
    set_word(3, 10'h3D3); in_valid = 4'b1000;
    #1;
    check("t5 out_valid full", out_valid, 4'b0111);
    check("t5 pre-init in_pop", in_pop, 4'b1000);
    init = 1'b1;
    #1 check("t5 init in_pop", in_pop, 4'b0000);
    cyc();
    init = 1'b0;
    #1;
    check("t5 out_valid", out_valid, 4'b0000);
    check("t5 out_data", out_data, 0);
    check("t5 fwd_cnt", fwd_cnt, 0);
    check("t5 drop_cnt", drop_cnt, 0);
    check("t5 INIT in_pop", in_pop, 4'b0000);
    cyc();
    out_ready = '1; in_valid = 4'b1111;
    #1 check("t5 ptr restart", in_pop, 4'b0001);
    cyc();
    #1 check("t5 rr next", in_pop, 4'b0010);
    in_valid = '0;
    cyc(2);

    // Asynchronous reset between edges
    out_ready = '0; arb_mode = 1'b0; in_valid = 4'b0001;
    cyc();
    #3 reset_L = 1'b0;
    #1;
    check("t6 async out_valid", out_valid, 4'b0000);
    check("t6 async out_data", out_data, 0);
    check("t6 async fwd_cnt", fwd_cnt, 0);
    check("t6 async active", active, 0);
    check("t6 async in_pop", in_pop, 4'b0000);
    cyc();
    reset_L = 1'b1; in_valid = '0; out_ready = '1;
    cyc(2);

    // Three-channel instance: destination 3 is out of range
    in_data3[0 +: DW] = 10'h3FF; in_valid3 = 3'b001;
    #1 check("t6 n3 drop in_pop", in_pop3, 3'b001);
    cyc();
    in_valid3 = '0;
    #1;
    check("t6 n3 out_valid", out_valid3, 3'b000);
    check("t6 n3 drop_cnt", drop_cnt3, 1);
    in_data3[1*DW +: DW] = 10'h2EE; in_valid3 = 3'b010;
    #1 check("t6 n3 store in_pop", in_pop3, 3'b010);
    cyc();
    in_valid3 = '0;
    #1;
    check("t6 n3 slot2", out_data3[2*DW +: DW], 10'h2EE);
    check("t6 n3 out_valid2", out_valid3, 3'b100);
    check("t6 n3 drop_cnt held", drop_cnt3, 1);
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_rr_router.md
Name: mux_rr_router

Overview:
Parametrised successor of the transaction-layer 4-to-4 priority mux. It takes NUM_CH input FIFO heads and forwards one word per cycle to the output selected by the word's destination field. Selectable arbitration is fixed-priority or round-robin, with a one-entry registered output slot per destination and per-output backpressure. It sits between the per-VC input FIFOs and the per-destination output FIFOs, and is driven by the link-layer init/active state.

Parameters:
NUM_CH, 4, number of input channels and of output destinations (2..8)
DATA_W, 10, word width including destination field
DEST_W, 2, destination field width; field is in_data word bits [DATA_W-1 -: DEST_W]; requires 2**DEST_W >= NUM_CH
CNT_W, 8, width of per-output forwarded counters and of the drop counter

Ports:
clk  in  1  single clock, rising edge
reset_L  in  1  asynchronous reset, active low
init  in  1  synchronous flush/hold (link INIT state)
arb_mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin
in_data  in  NUM_CH*DATA_W  input FIFO head words, channel i at [i*DATA_W +: DATA_W]
in_valid  in  NUM_CH  input FIFO non-empty
in_pop  out  NUM_CH  combinational one-hot pop to the granted input FIFO
out_data  out  NUM_CH*DATA_W  registered output words, per destination
out_valid  out  NUM_CH  output slot holds a word
out_ready  in  NUM_CH  downstream accepts the slot this cycle (FIFO not full)
fwd_cnt  out  NUM_CH*CNT_W  words delivered per destination
drop_cnt  out  CNT_W  words dropped for out-of-range destination
active  out  1  high while in ACTIVE state

Behaviour:
- Reset (reset_L=0, async): all registered outputs = 0; counters = 0; RR pointer = 0; state = INIT. in_pop = 0 while reset_L=0.
- FSM states are INIT, IDLE, ACTIVE.
  - INIT -> IDLE when init=0.
  - IDLE -> ACTIVE on the first grant.
  - ACTIVE -> IDLE after a cycle with no grant and all out_valid=0.
  - Any state -> INIT when init=1, synchronous, takes effect at the next edge.
- INIT: in_pop=0; out_valid, out_data, counters cleared at each edge; pointer = 0. An init mid-operation discards held slot contents. No partial forwarding occurs.
- Slot free condition: slot d is free if out_valid[d]=0 or out_ready[d]=1 this cycle, so a full slot drains and refills in the same edge.
- Eligibility: input i is eligible if in_valid[i]=1 and dest(i) < NUM_CH and slot dest(i) is free. An input whose destination is blocked is skipped, so other inputs still progress (no cross-input head-of-line blocking).
- Out-of-range destination: if dest(i) >= NUM_CH, the input is always eligible. On grant it is popped, not stored, and drop_cnt increments.
- Grant: at most one per cycle, combinational from the current inputs.
  - Fixed mode: lowest eligible index wins.
  - RR mode: first eligible index at or after the pointer, wrapping modulo NUM_CH.
  - in_pop[g]=1 in the grant cycle only.
- Slot load: the granted word is loaded into slot dest(g) at the next edge (1-cycle latency, pop to out_valid). out_data[d] equals the stored word while out_valid[d]=1, otherwise 0.
- Slot drain: when out_valid[d]=1 and out_ready[d]=1 at an edge, the slot drains, fwd_cnt[d] increments, and out_valid[d] clears unless refilled in the same edge.
- Pointer: in RR mode, after a grant to g, pointer = (g+1) mod NUM_CH. No grant leaves the pointer unchanged. Fixed mode holds the pointer. Switching arb_mode takes effect in the same cycle.
- Counters wrap at 2**CNT_W.
- Simultaneous events: init=1 overrides grant and drain; drop and store never occur in the same cycle (one grant).

Decomposition:
- Shared package (tl_pkg):
  - state encoding localparams ST_INIT=2'd0, ST_IDLE=2'd1, ST_ACTIVE=2'd2
  - ARB_FIXED/ARB_RR constants
  - clog2 function
- Sub-module rr_arbiter (NUM_CH). It takes the request vector, pointer and mode, and returns the one-hot grant and grant index. It is reused by the future per-VC credit arbiter.

Test Plan (NUM_CH=4, DATA_W=10, DEST_W=2):
1. Basic forwarding: release reset, init=0, in_valid=4'b0001, in_data[0]=10'h2A5, out_ready=all 1 -> in_pop=4'b0001 that cycle; next cycle out_valid=4'b0100, out_data[2]=10'h2A5; fwd_cnt[2]=1 one cycle later.
2. Arbitration modes: inputs 0..3 all valid, destinations 0,1,2,3, all out_ready high.
   - Fixed mode: pops 0 every cycle while its FIFO stays non-empty.
   - RR mode: pops in order 0,1,2,3,0.
3. Backpressure bypass: slot 1 full with out_ready[1]=0; input 0 -> dest1, input 2 -> dest3 -> input 0 not popped; input 2 popped; out_valid[3]=1 next cycle; slot 1 word unchanged.
4. Drain and refill: slot 0 full, out_ready[0]=1, a new dest-0 word granted in the same cycle -> out_valid[0] stays 1 with the new word; fwd_cnt[0] +1.
5. Init mid-stream: pulse init=1 for 1 cycle with 3 slots full -> next edge all out_valid=0, out_data=0, counters=0; no in_pop during init; pointer restarts at 0.
6. Async reset: drop reset_L between clock edges -> outputs 0 immediately without a clock edge. Also run NUM_CH=3, DEST_W=2 with dest=3 -> word popped, no slot loaded, drop_cnt=1.
